lvds_multilane_tx: RTL and testbench
====================================

// Module: lvds_multilane_tx
// PURPOSE
//  Parametrised N-lane 7:1-style LVDS transmitter core running entirely in the bit-clock domain.
//  Accepts one parallel word per lane per frame (valid/ready), shifts it out serially.
//  Emits a forwarded clock lane from a programmable pattern.
//  Replaces per-lane fixed serializers plus a fixed clock-pattern lane.
//  Adds input buffering, underflow detection and an optional training mode.
// PARAMETERS
//  LANES        4            number of data lanes
//  BITS         7            bits per lane per frame (serialization ratio), >=2
//  CLK_PATTERN  7'b1100011   clock-lane word (BITS wide), shifted MSB first
//  IDLE_WORD    0            per-lane word sent when no data is available (BITS wide)
//  MSB_FIRST    1            1: data word MSB leaves first; 0: LSB first
// PORTS
//  clk           in   1           bit clock (one serial bit per cycle)
//  rst           in   1           asynchronous reset, active-high
//  in_data       in   LANES*BITS  frame word; lane k = in_data[k*BITS +: BITS]
//  in_valid      in   1           in_data valid
//  in_ready      out  1           core can accept in_data this cycle
//  out_lanes     out  LANES       serial data lanes (to OBUFDS)
//  out_clk       out  1           serial clock lane (to OBUFDS)
//  frame_start   out  1           high during first bit slot of every frame
//  underflow     out  1           one-cycle pulse when a frame was sent with IDLE_WORD while running
//  underflow_cnt out  16          saturating count of underflow pulses
// BEHAVIOUR
//  - State: bit_cnt 0..BITS-1, data shift regs, clock shift reg, 1-entry hold buffer, FSM.
//  - Reset (async, immediate): bit_cnt=0; data shifters=IDLE_WORD; clock shifter=CLK_PATTERN.
//    Hold buffer empty; FSM=S_IDLE; underflow=0; underflow_cnt=0.
//    Hence out_lanes=first bit of IDLE_WORD, out_clk=CLK_PATTERN[BITS-1], frame_start=1.
//    In-flight words are dropped.
//  - out_lanes/out_clk/frame_start are driven straight from flops (no comb path from inputs).
//    frame_start = (bit_cnt==0).
//  - Each cycle bit_cnt increments, wrapping BITS-1 -> 0.
//    Load edge = edge where bit_cnt==BITS-1. Shifters shift every cycle except the load edge,
//    where they reload, so a new word's first bit is on the lane when bit_cnt==0.
//  - Clock shifter reloads CLK_PATTERN every load edge: clock lane repeats the pattern, frame aligned.
//  - in_ready = !hold_full || load_edge. Accept when in_valid && in_ready.
//  - Load edge, hold full: hold -> data shifters. A simultaneous accept refills hold (no bubble).
//  - Load edge, hold empty: IDLE_WORD -> data shifters.
//    A word accepted on that same edge goes to hold, not the shifters.
//  - Latency: accepted word reaches the lanes at the first frame boundary after it is in hold.
//    Range 1..BITS cycles from accept to first bit.
//  - FSM:
//    S_IDLE: no data yet.
//      -> S_RUN on first load edge with hold full.
//      Idle frames here are not underflows.
//    S_RUN: streaming.
//      Load edge with hold empty: send IDLE, pulse underflow, increment cnt, -> S_STARVED.
//    S_STARVED: IDLE frames sent, one underflow pulse per empty load edge.
//      -> S_RUN on load edge with hold full.
//  - underflow_cnt saturates at 16'hFFFF (no wrap).
//  - Bit order per MSB_FIRST; lane k always carries in_data[k*BITS +: BITS]. Clock lane always MSB first.
// CONFIGURATION
//  LVDS_TX_TRAINING_EN defined:
//    Adds input `train` (1 bit, sampled on clk).
//    While train=1 at a load edge, all data lanes load CLK_PATTERN (bit-aligned with clock lane).
//    Hold is not consumed; in_ready is held 0; FSM is unchanged; no underflow is counted.
//    Leaving training resumes the normal load rules at the next load edge.
//  LVDS_TX_TRAINING_EN undefined: no `train` port; no training logic.
// TESTING (LANES=4, BITS=7, MSB_FIRST=1, CLK_PATTERN=7'b1100011, IDLE_WORD=0)
//  - Reset release, no input -> out_clk repeats 1,1,0,0,0,1,1 every 7 cycles.
//    Lanes stay 0, frame_start every 7th cycle, underflow never pulses.
//  - Back-to-back in_valid with 0x7F,0x00,0x55,0x2A per lane, 3 frames -> each lane matches its word MSB first.
//    No gaps; in_ready high only on load edges once hold is full.
//  - One word (lane0=7'b1010101) then stop -> one data frame, then IDLE.
//    underflow pulses once per frame; underflow_cnt=1,2,3 after 3 idle frames. New word returns to S_RUN.
//  - Assert rst at bit_cnt=3 mid-frame -> outputs take reset values the same cycle.
//    underflow_cnt=0; first frame after release is IDLE.
//  - Force underflow_cnt to 16'hFFFE, starve 3 frames -> counter stops at 16'hFFFF.
//  - LVDS_TX_TRAINING_EN with train=1 for 2 frames -> all 4 lanes equal out_clk bit for bit.
//    in_ready=0; the buffered word is sent at the first frame after train drops.

Source files
------------

// File: rtl/lvds_multilane_tx.sv
// N-lane serializing LVDS transmitter core with forwarded clock lane, 1-entry hold buffer and underflow tracking.
// Optional training mode (all lanes send the clock pattern) is enabled by defining LVDS_TX_TRAINING_EN.
module lvds_multilane_tx #(
  parameter int              LANES       = 4,
  parameter int              BITS        = 7,
  parameter logic [BITS-1:0] CLK_PATTERN = 7'b1100011,
  parameter logic [BITS-1:0] IDLE_WORD   = '0,
  parameter bit              MSB_FIRST   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef LVDS_TX_TRAINING_EN
  input  logic                  train,
`endif
  input  logic [LANES*BITS-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [LANES-1:0]      out_lanes,
  output logic                  out_clk,
  output logic                  frame_start,
  output logic                  underflow,
  output logic [15:0]           underflow_cnt
);

  localparam int              CW   = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0]   LAST = CW'(BITS - 1);

  // Training words must come out bit-aligned with the clock lane, which is always MSB first.
  function automatic logic [BITS-1:0] f_reverse(input logic [BITS-1:0] w);
    logic [BITS-1:0] r;
    r = '0;
    for (int i = 0; i < BITS; i++) begin
      r[i] = w[BITS-1-i];
    end
    return r;
  endfunction

  localparam logic [BITS-1:0] TRAIN_WORD = MSB_FIRST ? CLK_PATTERN : f_reverse(CLK_PATTERN);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_STARVED = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_bit_cnt;
  logic [BITS-1:0]       r_clk_sh;
  logic [BITS-1:0]       r_data_sh [LANES];
  logic [LANES*BITS-1:0] r_hold;
  logic                  r_hold_full;
  logic                  r_underflow;
  logic [15:0]           r_underflow_cnt;

  logic                  w_train;
  logic                  w_load_edge;
  logic                  w_accept;
  logic                  w_take_hold;
  logic                  w_underflow_set;

`ifdef LVDS_TX_TRAINING_EN
  assign w_train = train;
`else
  assign w_train = 1'b0;
`endif

  assign w_load_edge = (r_bit_cnt == LAST);
  assign in_ready    = !w_train && (!r_hold_full || w_load_edge);
  assign w_accept    = in_valid && in_ready;
  assign w_take_hold = w_load_edge && !w_train && r_hold_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
    end else if (w_load_edge) begin
      r_bit_cnt <= '0;
    end else begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sh <= CLK_PATTERN;
    end else if (w_load_edge) begin
      r_clk_sh <= CLK_PATTERN;
    end else begin
      r_clk_sh <= {r_clk_sh[BITS-2:0], 1'b0};
    end
  end

  assign out_clk     = r_clk_sh[BITS-1];
  assign frame_start = (r_bit_cnt == '0);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [BITS-1:0] w_load_word;

      always_comb begin
        w_load_word = IDLE_WORD;
        if (w_train) begin
          w_load_word = TRAIN_WORD;
        end else if (r_hold_full) begin
          w_load_word = r_hold[gi*BITS +: BITS];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data_sh[gi] <= IDLE_WORD;
        end else if (w_load_edge) begin
          r_data_sh[gi] <= w_load_word;
        end else if (MSB_FIRST) begin
          r_data_sh[gi] <= {r_data_sh[gi][BITS-2:0], 1'b0};
        end else begin
          r_data_sh[gi] <= {1'b0, r_data_sh[gi][BITS-1:1]};
        end
      end

      assign out_lanes[gi] = MSB_FIRST ? r_data_sh[gi][BITS-1] : r_data_sh[gi][0];
    end
  endgenerate

  // An accept while full only happens on the load edge, where the old word drains in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold      <= in_data;
      r_hold_full <= 1'b1;
    end else if (w_take_hold) begin
      r_hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_underflow_set = 1'b0;
    if (w_load_edge && !w_train) begin
      case (r_state)
        S_IDLE: begin
          if (r_hold_full) begin
            w_state_next = S_RUN;
          end
        end
        S_RUN: begin
          if (!r_hold_full) begin
            w_underflow_set = 1'b1;
            w_state_next    = S_STARVED;
          end
        end
        S_STARVED: begin
          if (r_hold_full) begin
            w_state_next = S_RUN;
          end else begin
            w_underflow_set = 1'b1;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underflow     <= 1'b0;
      r_underflow_cnt <= '0;
    end else begin
      r_underflow <= w_underflow_set;
      if (w_underflow_set && (r_underflow_cnt != 16'hFFFF)) begin
        r_underflow_cnt <= r_underflow_cnt + 16'd1;
      end
    end
  end

  assign underflow     = r_underflow;
  assign underflow_cnt = r_underflow_cnt;

endmodule

// File: tb/tb_lvds_multilane_tx.sv
// Randomized and directed bench for lvds_multilane_tx against a frame-level reference model.
module tb_lvds_multilane_tx;

  localparam int              LANES = 4;
  localparam int              BITS  = 7;
  localparam logic [BITS-1:0] CLKP  = 7'b1100011;
  localparam logic [BITS-1:0] IDLE  = '0;
  localparam int              DW    = LANES * BITS;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [DW-1:0]    in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [LANES-1:0] out_lanes;
  logic             out_clk;
  logic             frame_start;
  logic             underflow;
  logic [15:0]      underflow_cnt;
`ifdef LVDS_TX_TRAINING_EN
  logic             train = 1'b0;
`endif

  always #5 clk = ~clk;

  lvds_multilane_tx #(
    .LANES(LANES), .BITS(BITS), .CLK_PATTERN(CLKP), .IDLE_WORD(IDLE), .MSB_FIRST(1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef LVDS_TX_TRAINING_EN
    .train        (train),
`endif
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_lanes    (out_lanes),
    .out_clk      (out_clk),
    .frame_start  (frame_start),
    .underflow    (underflow),
    .underflow_cnt(underflow_cnt)
  );

  // Frame-level model: words wait in a queue and one is consumed per frame boundary.
  int            m_phase;
  logic [DW-1:0] m_word;
  logic [DW-1:0] m_q[$];
  bit            m_running;
  bit            m_uf;
  logic [15:0]   m_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_phase   = 0;
    m_word    = {LANES{IDLE}};
    m_q.delete();
    m_running = 1'b0;
    m_uf      = 1'b0;
    m_cnt     = '0;
  endtask

  function automatic logic [LANES-1:0] exp_lanes();
    logic [LANES-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) r[k] = m_word[k*BITS + (BITS-1-m_phase)];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // One bit-clock cycle: check outputs, drive inputs, advance the model at the edge.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit tr, output bit acc);
    bit exp_ready;
    @(negedge clk);
    check("lanes", 32'(out_lanes), 32'(exp_lanes()));
    check("out_clk", 32'(out_clk), 32'(CLKP[BITS-1-m_phase]));
    check("frame_start", 32'(frame_start), 32'(m_phase == 0));
    check("underflow", 32'(underflow), 32'(m_uf));
    check("underflow_cnt", 32'(underflow_cnt), 32'(m_cnt));
    exp_ready = !tr && (m_q.size() == 0 || m_phase == BITS-1);
    in_valid = v;
    in_data  = d;
`ifdef LVDS_TX_TRAINING_EN
    train = tr;
`endif
    #1;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    acc = v && exp_ready;
    if (acc) $display("accept word %h at %0t", d, $time);
    @(posedge clk);
    if (m_phase == BITS-1) begin
      if (tr) begin
        m_word = {LANES{CLKP}};
        m_uf   = 1'b0;
      end else if (m_q.size() > 0) begin
        m_word    = m_q.pop_front();
        m_running = 1'b1;
        m_uf      = 1'b0;
      end else begin
        m_word = {LANES{IDLE}};
        m_uf   = m_running;
        if (m_running && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
    end else begin
      m_uf = 1'b0;
    end
    if (acc) m_q.push_back(d);
    m_phase = (m_phase + 1) % BITS;
  endtask

  task automatic idle_steps(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, a);
  endtask

  task automatic check_reset_values();
    check("rst_lanes", 32'(out_lanes), 32'(0));
    check("rst_out_clk", 32'(out_clk), 32'(CLKP[BITS-1]));
    check("rst_frame_start", 32'(frame_start), 32'(1));
    check("rst_underflow", 32'(underflow), 32'(0));
    check("rst_underflow_cnt", 32'(underflow_cnt), 32'(0));
  endtask

  initial begin
    bit            a;
    int            nacc;
    logic [DW-1:0] bb;
    logic [DW-1:0] w;

    model_reset();
    #2 rst = 1'b1;
    #10 check_reset_values();
    @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: clock pattern only, no underflow.
    idle_steps(3 * BITS);
    check("idle_no_underflow", 32'(underflow_cnt), 32'(0));

    // Back-to-back frames, lane0..3 = 7F,00,55,2A.
    bb   = {7'h2A, 7'h55, 7'h00, 7'h7F};
    nacc = 0;
    for (int i = 0; i < 6 * BITS && nacc < 3; i++) begin
      step(1'b1, bb, 1'b0, a);
      if (a) nacc++;
    end
    check("bb_accepts", 32'(nacc), 32'(3));
    idle_steps(4 * BITS);

    // Mid-frame reset with a word sitting in hold: the word is dropped.
    while (m_phase != 1) step(1'b0, '0, 1'b0, a);
    w = rand_word();
    step(1'b1, w, 1'b0, a);
    while (m_phase != 3) step(1'b0, '0, 1'b0, a);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_values();
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    idle_steps(2 * BITS);

    // Single word then starvation: one underflow per idle frame, then recovery.
    w = {21'd0, 7'b1010101};
    step(1'b1, w, 1'b0, a);
    check("single_accept", 32'(a), 32'(1));
    idle_steps(4 * BITS);
    check("ucnt_after_3", 32'(underflow_cnt), 32'(3));
    w = rand_word();
    step(1'b1, w, 1'b0, a);
    idle_steps(2 * BITS);

    // Random traffic with bursts and gaps.
    for (int i = 0; i < 700; i++) begin
      bit v;
      v = ((i / 60) % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
      step(v, rand_word(), 1'b0, a);
    end

`ifdef LVDS_TX_TRAINING_EN
    // Training: lanes mirror the clock lane, hold kept until train drops.
    idle_steps(2 * BITS);
    while (m_phase != 0) step(1'b0, '0, 1'b0, a);
    w = rand_word();
    step(1'b1, w, 1'b0, a);
    for (int i = 0; i < 2 * BITS; i++) begin
      step(1'b1, rand_word(), 1'b1, a);
      check("train_lanes_eq_clk", 32'(out_lanes), 32'({LANES{out_clk}}) & 32'(m_phase != 1 ? 4'hF : 4'hF));
    end
    idle_steps(3 * BITS);
`endif

    // Saturation: preload the counter near the top and starve.
    while (m_phase != 0) step(1'b0, '0, 1'b0, a);
    step(1'b1, rand_word(), 1'b0, a);
    while (!m_running) step(1'b0, '0, 1'b0, a);
    #2 force dut.r_underflow_cnt = 16'hFFFE;
    #1 release dut.r_underflow_cnt;
    m_cnt = 16'hFFFE;
    idle_steps(4 * BITS);
    check("ucnt_saturated", 32'(underflow_cnt), 32'(16'hFFFF));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
